// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: registered Moore decode, strobes gated combinationally by mem_ready (stalls FETCH/MEMRD/MEMWR).
// Optional BNE support under `define BNE_EN; without it OP_BNE is treated as illegal.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Branch,
  output logic       BranchNe,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BNE   = 6'h05;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  // *_mr fields are requests that only fire in a cycle where mem_ready is high.
  typedef struct packed {
    logic       iord;
    logic       memwrite_mr;
    logic       irwrite_mr;
    logic       pcwrite_mr;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite_mr = 1'b1;
        c.pcwrite_mr = 1'b1;
        c.alusrcb    = 2'b01;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord        = 1'b1;
        c.memwrite_mr = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_t state;
  state_t nxt;
  ctrl_t  ctl;
  logic   live;

  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = EXECUTE;
          OP_BEQ:       nxt = BRANCH;
`ifdef BNE_EN
          OP_BNE:       nxt = BRANCH;
`endif
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR: begin
        if (Op == OP_LW)      nxt = MEMRD;
        else if (Op == OP_SW) nxt = MEMWR;
        else                  nxt = FETCH;
      end
      MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
      MEMWB:   nxt = FETCH;
      MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
      EXECUTE: nxt = ALUWB;
      ALUWB:   nxt = FETCH;
      BRANCH:  nxt = FETCH;
      ADDIEX:  nxt = ADDIWB;
      ADDIWB:  nxt = FETCH;
      JUMP:    nxt = FETCH;
      default: nxt = FETCH;
    endcase
  end

  // Decode of the next state is registered alongside it so outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctl   <= decode(FETCH);
    end else begin
      state <= nxt;
      ctl   <= decode(nxt);
    end
  end

  assign live = ~reset;

  assign IorD       = live & ctl.iord;
  assign MemWrite   = live & ctl.memwrite_mr & mem_ready;
  assign IRWrite    = live & ctl.irwrite_mr & mem_ready;
  assign RegDst     = live & ctl.regdst;
  assign MemtoReg   = live & ctl.memtoreg;
  assign RegWrite   = live & ctl.regwrite;
  assign ALUSrcA    = live & ctl.alusrca;
  assign ALUSrcB    = {2{live}} & ctl.alusrcb;
  assign ALUOp      = {2{live}} & ctl.aluop;
  assign PCSrc      = {2{live}} & ctl.pcsrc;
  assign PCWrite    = live & (ctl.pcwrite | (ctl.pcwrite_mr & mem_ready));
  assign Branch     = live & ctl.branch;
  assign illegal_op = live & (state == DECODE) & (nxt == FETCH);
  assign state_dbg  = {4{live}} & state;

`ifdef BNE_EN
  assign BranchNe = live & (state == BRANCH) & (Op == OP_BNE);
`else
  assign BranchNe = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: every cycle compares the full control word against hand-built expectations.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCWrite, Branch, BranchNe, illegal_op;
  logic [3:0] state_dbg;

  int total;
  int bad;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       illegal;
    logic [3:0] st;
  } ctl_t;

  ctl_t obs;
  assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, BranchNe, illegal_op, state_dbg};

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite), .Branch(Branch),
    .BranchNe(BranchNe), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-transcribed Moore table, no handshake strobes.
  function automatic ctl_t st_exp(input int s);
    ctl_t e;
    e    = '0;
    e.st = 4'(s);
    case (s)
      0:  e.alusrcb = 2'b01;
      1:  e.alusrcb = 2'b11;
      2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      3:  e.iord = 1'b1;
      4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      5:  e.iord = 1'b1;
      6:  begin e.alusrca = 1'b1; e.aluop = 2'b10; end
      7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      8:  begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.branch = 1'b1; end
      9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      10: e.regwrite = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t fetch_go();
    ctl_t e;
    e = st_exp(0);
    e.irwrite = 1'b1;
    e.pcwrite = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input ctl_t e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic step(input logic mr, input logic [5:0] op, input string tag, input ctl_t e);
    @(negedge clk);
    mem_ready = mr;
    Op        = op;
    #1;
    check(tag, e);
  endtask

  initial begin
    ctl_t e;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    mem_ready = 1'b1;
    Op        = 6'h23;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("reset_hold", '0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_release_fetch", fetch_go());

    // LW: 0,1,2,3,4,0
    step(1'b1, 6'h23, "lw_decode", st_exp(1));
    step(1'b1, 6'h23, "lw_memadr", st_exp(2));
    step(1'b1, 6'h23, "lw_memrd", st_exp(3));
    step(1'b1, 6'h23, "lw_memwb", st_exp(4));

    // FETCH stall, then SW with two wait cycles in MEMWR
    step(1'b0, 6'h2B, "fetch_stall", st_exp(0));
    step(1'b1, 6'h2B, "sw_fetch", fetch_go());
    step(1'b1, 6'h2B, "sw_decode", st_exp(1));
    step(1'b1, 6'h2B, "sw_memadr", st_exp(2));
    step(1'b0, 6'h2B, "sw_memwr_wait1", st_exp(5));
    step(1'b0, 6'h2B, "sw_memwr_wait2", st_exp(5));
    e = st_exp(5);
    e.memwrite = 1'b1;
    step(1'b1, 6'h2B, "sw_memwr_done", e);

    // BEQ: 0,1,8,0
    step(1'b1, 6'h04, "beq_fetch", fetch_go());
    step(1'b1, 6'h04, "beq_decode", st_exp(1));
    step(1'b1, 6'h04, "beq_branch", st_exp(8));

    // Illegal opcode: 0,1,0 with a single illegal_op pulse
    step(1'b1, 6'h3F, "ill_fetch", fetch_go());
    e = st_exp(1);
    e.illegal = 1'b1;
    step(1'b1, 6'h3F, "ill_decode", e);
    step(1'b1, 6'h00, "ill_back_fetch", fetch_go());

    // R-type, with Op disturbed in EXECUTE/ALUWB where it must be ignored
    step(1'b1, 6'h00, "r_decode", st_exp(1));
    step(1'b1, 6'h3F, "r_execute", st_exp(6));
    step(1'b1, 6'h3F, "r_aluwb", st_exp(7));

    // Jump
    step(1'b1, 6'h02, "j_fetch", fetch_go());
    step(1'b1, 6'h02, "j_decode", st_exp(1));
    step(1'b1, 6'h02, "j_jump", st_exp(11));

    // BNE
    step(1'b1, 6'h05, "bne_fetch", fetch_go());
`ifdef BNE_EN
    step(1'b1, 6'h05, "bne_decode", st_exp(1));
    e = st_exp(8);
    e.branchne = 1'b1;
    step(1'b1, 6'h05, "bne_branch", e);
    step(1'b1, 6'h08, "addi_fetch", fetch_go());
`else
    e = st_exp(1);
    e.illegal = 1'b1;
    step(1'b1, 6'h05, "bne_decode_illegal", e);
    step(1'b1, 6'h08, "bne_back_fetch", fetch_go());
`endif

    // ADDI interrupted by reset in ADDIWB, then a full ADDI
    step(1'b1, 6'h08, "addi_decode", st_exp(1));
    step(1'b1, 6'h08, "addi_ex", st_exp(9));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_mid_instr", '0);
    @(negedge clk);
    #1;
    check("reset_mid_hold", '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_mid_release", fetch_go());
    step(1'b1, 6'h08, "addi2_decode", st_exp(1));
    step(1'b1, 6'h08, "addi2_ex", st_exp(9));
    step(1'b1, 6'h08, "addi2_wb", st_exp(10));
    step(1'b1, 6'h08, "addi2_fetch", fetch_go());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle CPU datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath enable and mux select, including Branch, which the downstream branch AND gate combines with the ALU Zero flag. Stalls on a memory-ready handshake so slow memory models can be attached.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-equal opcode
OP_ADDI, 6'h08, add-immediate opcode
OP_J, 6'h02, jump opcode
OP_BNE, 6'h05, branch-not-equal opcode (used only with BNE_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Op  in  6  opcode field from the instruction register
mem_ready  in  1  memory access complete this cycle
IorD  out  1  0=PC address, 1=ALUOut address
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegDst  out  1  1=rd, 0=rt
MemtoReg  out  1  1=MDR, 0=ALUOut to register file
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0=PC, 1=A register
ALUSrcB  out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
ALUOp  out  2  00=add, 01=sub, 10=funct-decoded
PCSrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
PCWrite  out  1  unconditional PC write
Branch  out  1  conditional PC write request to the branch AND gate
BranchNe  out  1  invert Zero sense for the branch (BNE_EN only, else tied 0)
illegal_op  out  1  one-cycle pulse on an unsupported opcode
state_dbg  out  4  current state encoding

Behaviour:
- State register is 4 bits, reset asynchronously to FETCH(0). Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Outputs are Moore (state only) except the handshake-gated strobes noted below. All outputs not listed for a state are 0.
- While reset is high, every output is 0, including IRWrite, PCWrite and MemWrite. state_dbg is 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - Hold FETCH while mem_ready=0; move to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
  - LW/SW → MEMADR
  - RTYPE → EXECUTE
  - BEQ → BRANCH
  - ADDI → ADDIEX
  - J → JUMP
  - anything else → FETCH, with illegal_op=1 for exactly that cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if Op=LW, MEMWR if Op=SW.
- MEMRD: IorD=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH.
- MEMWR: IorD=1. MemWrite is asserted only when mem_ready=1. Hold until mem_ready=1, then go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Goes to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
- Cycle counts with mem_ready held at 1:
  - LW 5; SW 4; R-type 4; ADDI 4; BEQ 3; J 3; illegal 2.
  - Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Op is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- Reset asserted mid-instruction: the state returns to FETCH immediately, and no write strobe is emitted on the cycle reset is released.

Optional Feature:
BNE_EN
- Defined: Op=OP_BNE decodes to BRANCH, and BranchNe=1 in BRANCH whenever Op=OP_BNE. The datapath uses Branch & ~Zero in that case.
- Undefined: OP_BNE is illegal (returns to FETCH, illegal_op pulse) and BranchNe is constant 0.

Test Plan:
- Reset held 3 cycles, mem_ready=1 → all outputs 0 during reset. First cycle after release: state_dbg=0, IRWrite=1, PCWrite=1.
- Op=6'h23, mem_ready=1 → state sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- Op=6'h2B, mem_ready low for 2 cycles in MEMWR → state 5 held 3 cycles. MemWrite=1 only in the third cycle, then state 0.
- Op=6'h04 → states 0,1,8,0. Branch=1, ALUOp=01, PCSrc=01 in state 8. PCWrite=0 throughout BRANCH.
- Op=6'h3F → states 0,1,0. illegal_op high exactly 1 cycle, and no RegWrite or MemWrite asserted.
- Op=6'h05 with BNE_EN defined → states 0,1,8 with Branch=1, BranchNe=1. Without BNE_EN → illegal_op pulse and BranchNe stays 0.
